mdu_ctrl: RTL and testbench

Multiply/divide unit controller for the E stage of the five-stage pipeline. It accepts mult/multu/div/divu from E and sequences a fixed-latency busy window that models multi-cycle hardware. It owns the HI/LO register pair and serves mfhi/mflo/mthi/mtlo. It also raises the D-stage stall request for any MDU instruction that would collide with an operation in flight.

---
 rtl/mdu_ctrl_pkg.sv | 23 ++
 rtl/mdu_arith.sv | 29 ++
 rtl/mdu_ctrl.sv | 93 +++++++++
 tb/tb_mdu_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: MDU operation codes, FSM states and default busy-cycle counts
package mdu_ctrl_pkg;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;
  typedef enum logic [3:0] {
    MDU_none  = 4'd0,
    MDU_mult  = 4'd1,
    MDU_multu = 4'd2,
    MDU_div   = 4'd3,
    MDU_divu  = 4'd4,
    MDU_mfhi  = 4'd5,
    MDU_mflo  = 4'd6,
    MDU_mthi  = 4'd7,
    MDU_mtlo  = 4'd8
  } mdu_op_e;
  typedef enum logic {S_IDLE, S_BUSY} state_e;
  function automatic logic is_div_op(input logic [3:0] op);
    return op == MDU_div || op == MDU_divu;
  endfunction
  function automatic logic is_md_op(input logic [3:0] op);
    return op == MDU_mult || op == MDU_multu || is_div_op(op);
  endfunction
endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 64-bit product / quotient-remainder for the MDU
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [31:0] In0,
  input  logic [31:0] In1,
  input  logic [3:0]  MDUOp,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        wr
);
  logic sgn, dv;
  logic signed [32:0] a, b, bs;
  logic [63:0] ax, bx, p;
  // Extend operands to 33 bits, form product or quotient/remainder; a zero divisor suppresses the write
  always_comb begin
    sgn = MDUOp == MDU_mult || MDUOp == MDU_div;
    dv  = is_div_op(MDUOp);
    a   = {sgn & In0[31], In0};
    b   = {sgn & In1[31], In1};
    bs  = (In1 == '0) ? 33'sd1 : b;
    ax  = {{31{a[32]}}, a};
    bx  = {{31{b[32]}}, b};
    p   = ax * bx;
    hi  = dv ? 32'(a % bs) : p[63:32];
    lo  = dv ? 32'(a / bs) : p[31:0];
    wr  = !dv || In1 != '0;
  end
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: MDU busy-window FSM, HI/LO registers and D-stage stall request
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] In0,
  input  logic [31:0] In1,
  input  logic [3:0]  MDUOp,
  input  logic        Start,
  input  logic        DUsesMDU,
  output logic        Busy,
  output logic        StallReq,
  output logic [31:0] MDURes,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d, hi_q, hi_d, lo_q, lo_d;
  logic pend_wr_q, pend_wr_d;
  logic [31:0] ar_hi, ar_lo;
  logic ar_wr;

  mdu_arith u_arith (
    .In0   (In0),
    .In1   (In1),
    .MDUOp (MDUOp),
    .hi    (ar_hi),
    .lo    (ar_lo),
    .wr    (ar_wr)
  );

  // Next state: accept mult/div or mt* in IDLE, count down and retire the pending result in BUSY
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (state_q == S_IDLE) begin
      if (Start && is_md_op(MDUOp)) begin
        state_d   = S_BUSY;
        cnt_d     = is_div_op(MDUOp) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        pend_hi_d = ar_hi;
        pend_lo_d = ar_lo;
        pend_wr_d = ar_wr;
      end else begin
        hi_d = MDUOp == MDU_mthi ? In0 : hi_q;
        lo_d = MDUOp == MDU_mtlo ? In0 : lo_q;
      end
    end else begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        state_d = S_IDLE;
        hi_d    = pend_wr_q ? pend_hi_q : hi_q;
        lo_d    = pend_wr_q ? pend_lo_q : lo_q;
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign Busy     = state_q == S_BUSY;
  assign StallReq = DUsesMDU & (Start | Busy);
  assign MDURes   = MDUOp == MDU_mfhi ? hi_q : MDUOp == MDU_mflo ? lo_q : 32'd0;
  assign HI       = hi_q;
  assign LO       = lo_q;
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: scoreboard bench for mdu_ctrl with cycle-keyed expected values
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  localparam int S_BSY = 0, S_STL = 1, S_RES = 2, S_HI = 3, S_LO = 4;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
    string       nm;
  } exp_t;

  logic clk = 1'b0, reset_n = 1'b0, Start = 1'b0, DUsesMDU = 1'b0;
  logic [31:0] In0 = '0, In1 = '0;
  logic [3:0] MDUOp = MDU_none;
  logic Busy, StallReq;
  logic [31:0] MDURes, HI, LO;

  int cyc = 0;
  int n_vec = 0, n_mis = 0;
  exp_t sb[$];
  exp_t e;
  logic [31:0] act;
  logic [31:0] hi_m = '0, lo_m = '0;

  mdu_ctrl dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .In0      (In0),
    .In1      (In1),
    .MDUOp    (MDUOp),
    .Start    (Start),
    .DUsesMDU (DUsesMDU),
    .Busy     (Busy),
    .StallReq (StallReq),
    .MDURes   (MDURes),
    .HI       (HI),
    .LO       (LO)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  // Monitor: pop every expectation due this cycle and compare it to the DUT
  always @(negedge clk) begin
    if (reset_n && Busy && Start) begin
      n_mis++;
      $display("FAIL start_in_busy cyc %0d: got Start=1 while Busy, want no Start", cyc);
    end
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      act = e.sel == S_BSY ? {31'd0, Busy} : e.sel == S_STL ? {31'd0, StallReq} :
            e.sel == S_RES ? MDURes : e.sel == S_HI ? HI : LO;
      n_vec++;
      if (e.cyc != cyc || act !== e.val) begin
        n_mis++;
        $display("FAIL %s cyc %0d (due %0d): got %h want %h", e.nm, cyc, e.cyc, act, e.val);
      end
    end
  end

  function automatic void push(input int c, input int s, input logic [31:0] v, input string nm);
    sb.push_back('{c, s, v, nm});
  endfunction

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue one mult/div and queue its busy/stall/HI/LO expectations; returns in cycle k+n+1
  task automatic md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int n,
                    input logic [31:0] eh, input logic [31:0] el, input logic du,
                    input logic [3:0] iop = MDU_none, input logic [31:0] iv = '0);
    int k;
    k = cyc;
    Start = 1'b1; MDUOp = op; In0 = a; In1 = b; DUsesMDU = du;
    push(k, S_BSY, 0, "busy_c0");
    push(k, S_STL, {31'd0, du}, "stall_c0");
    for (int i = 1; i <= n; i++) begin
      push(k + i, S_BSY, 1, "busy_win");
      push(k + i, S_STL, {31'd0, du}, "stall_win");
    end
    push(k + n, S_HI, hi_m, "hi_old");
    push(k + n, S_LO, lo_m, "lo_old");
    push(k + n + 1, S_BSY, 0, "busy_end");
    push(k + n + 1, S_HI, eh, "hi_new");
    push(k + n + 1, S_LO, el, "lo_new");
    hi_m = eh; lo_m = el;
    step();
    Start = 1'b0; MDUOp = MDU_none; In0 = '0; In1 = '0;
    if (iop != MDU_none) begin
      MDUOp = iop; In0 = iv;
      step();
      MDUOp = MDU_none; In0 = '0;
      step(n - 1);
    end else step(n);
  endtask

  initial begin
    step(2);
    reset_n = 1'b1; DUsesMDU = 1'b1; MDUOp = MDU_mfhi;
    push(cyc, S_BSY, 0, "rst_busy");
    push(cyc, S_STL, 0, "rst_stall");
    push(cyc, S_RES, 0, "rst_mdures");
    push(cyc, S_HI, 0, "rst_hi");
    push(cyc, S_LO, 0, "rst_lo");
    step();
    md(MDU_mult, 32'hFFFFFFFF, 32'd2, 5, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1);
    MDUOp = MDU_mflo;
    push(cyc, S_STL, 0, "stall_release");
    push(cyc, S_RES, 32'hFFFFFFFE, "mflo_mult");
    step();
    DUsesMDU = 1'b0;
    md(MDU_multu, 32'hFFFFFFFF, 32'd2, 5, 32'h1, 32'hFFFFFFFE, 1'b0);
    md(MDU_div, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    md(MDU_divu, 32'd7, 32'd2, 10, 32'd1, 32'd3, 1'b0);
    md(MDU_div, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000, 1'b0);
    MDUOp = MDU_mthi; In0 = 32'h1234;
    push(cyc + 1, S_HI, 32'h1234, "mthi_1234");
    hi_m = 32'h1234;
    step();
    md(MDU_div, 32'd5, 32'd0, 10, 32'h1234, 32'h80000000, 1'b0);
    MDUOp = MDU_mthi; In0 = 32'hAAAA;
    push(cyc + 1, S_HI, 32'hAAAA, "mthi_aaaa");
    hi_m = 32'hAAAA;
    step();
    MDUOp = MDU_mfhi; In0 = '0;
    push(cyc, S_RES, 32'hAAAA, "mfhi_aaaa");
    step();
    MDUOp = MDU_mtlo; In0 = 32'h5555;
    push(cyc + 1, S_LO, 32'h5555, "mtlo_5555");
    lo_m = 32'h5555;
    step();
    MDUOp = MDU_mflo; In0 = '0;
    push(cyc, S_RES, 32'h5555, "mflo_5555");
    step();
    md(MDU_divu, 32'd9, 32'd0, 10, 32'hAAAA, 32'h5555, 1'b0, MDU_mtlo, 32'h7777);
    md(MDU_mult, 32'd3, 32'd4, 5, 32'd0, 32'd12, 1'b0);
    md(MDU_multu, 32'd6, 32'd7, 5, 32'd0, 32'd42, 1'b0);
    Start = 1'b1; MDUOp = MDU_div; In0 = 32'd100; In1 = 32'd7;
    step();
    Start = 1'b0; MDUOp = MDU_none;
    step(2);
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1; DUsesMDU = 1'b1; MDUOp = MDU_mflo;
    push(cyc, S_BSY, 0, "midrst_busy");
    push(cyc, S_STL, 0, "midrst_stall");
    push(cyc, S_HI, 0, "midrst_hi");
    push(cyc, S_LO, 0, "midrst_lo");
    push(cyc, S_RES, 0, "midrst_mflo");
    step();
    MDUOp = MDU_none; DUsesMDU = 1'b0;
    step(12);
    push(cyc, S_HI, 0, "abort_hi");
    push(cyc, S_LO, 0, "abort_lo");
    step();
    for (int i = 0; i < 20 && sb.size() > 0; i++) step();
    if (sb.size() > 0) begin
      n_mis++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
